uart_tx_ctrl: RTL and testbench

- Frame sequencer and serializer for the UART transmitter.
- Accepts a parallel byte with a valid strobe and walks the start → data → optional parity → stop sequence.
- Drives the TX output mux select, the serial data bit and the parity bit.
- Sits between the transmit-side register/FIFO interface and the TX output mux.

---
 rtl/uart_tx_ctrl_if.sv | 22 ++
 rtl/uart_tx_ctrl.sv | 107 ++++++++++
 tb/tb_uart_tx_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Handshake and line-side signals between the TX register/FIFO side,
// the frame sequencer and the TX output mux.
interface uart_tx_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  mux_sel, ser_data, par_bit, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output mux_sel, ser_data, par_bit, busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer/serializer: start, LSB-first data, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to stretch the stop period to two bit times.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (mux_sel 00)
// DATA   | payload bits LSB first (mux_sel 10)
// PARITY | parity bit (mux_sel 11)
// STOP   | stop bit(s), line high (mux_sel 01)
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_ctrl_if.slave tx
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         cnt_q;
  logic                  par_en_q;
  logic                  par_q;
  logic [1:0]            mux_sel_c;
  logic                  stop_done;

`ifdef UART_TX_TWO_STOP_EN
  logic stop_cnt_q;

  // Second STOP cycle is the one that returns to IDLE.
  always_ff @(posedge CLK) begin
    if (RST) stop_cnt_q <= 1'b0;
    else     stop_cnt_q <= (state == STOP) ? ~stop_cnt_q : 1'b0;
  end

  assign stop_done = stop_cnt_q;
`else
  assign stop_done = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mux_sel_c = 2'b01;
    case (state)
      IDLE: begin
        if (tx.Data_Valid) state_nxt = START;
      end
      START: begin
        mux_sel_c = 2'b00;
        state_nxt = DATA;
      end
      DATA: begin
        mux_sel_c = 2'b10;
        if (cnt_q == CNT_LAST) state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        mux_sel_c = 2'b11;
        state_nxt = STOP;
      end
      STOP: begin
        if (stop_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload and parity settings are captured once so the frame in flight is immune to input changes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx.Data_Valid) begin
            shift_q  <= tx.P_DATA;
            cnt_q    <= '0;
            par_en_q <= tx.PAR_EN;
            par_q    <= tx.PAR_TYP ? ~^tx.P_DATA : ^tx.P_DATA;
          end
        end
        DATA: begin
          shift_q <= shift_q >> 1;
          if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tx.mux_sel  = mux_sel_c;
  assign tx.ser_data = shift_q[0];
  assign tx.par_bit  = par_q;
  assign tx.busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl: table of frames plus hand-written corner sequences.
module tb_uart_tx_ctrl;

`ifdef UART_TX_TWO_STOP_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic CLK = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) tx ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .tx  (tx.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       exp_par;
    int         exp_busy;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks one frame starting at the START cycle, through the last stop cycle.
  // Returns the number of cycles busy was observed high.
  task automatic check_frame(input logic [7:0] data, input logic pe, input logic exp_par,
                             output int busy_cnt);
    busy_cnt = 0;
    chk("start_mux", {6'd0, tx.mux_sel}, 8'h00);
    chk("start_par", {7'd0, tx.par_bit}, {7'd0, exp_par});
    if (tx.busy) busy_cnt++;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("data_mux", {6'd0, tx.mux_sel}, 8'h02);
      chk("data_bit", {7'd0, tx.ser_data}, {7'd0, data[i]});
      if (tx.busy) busy_cnt++;
    end
    if (pe) begin
      @(negedge CLK);
      chk("par_mux", {6'd0, tx.mux_sel}, 8'h03);
      chk("par_bit", {7'd0, tx.par_bit}, {7'd0, exp_par});
      if (tx.busy) busy_cnt++;
    end
    for (int i = 0; i < S; i++) begin
      @(negedge CLK);
      chk("stop_mux", {6'd0, tx.mux_sel}, 8'h01);
      chk("stop_busy", {7'd0, tx.busy}, 8'h01);
      if (tx.busy) busy_cnt++;
    end
  endtask

  // Drives a request in IDLE, scrambles inputs after acceptance, checks the whole frame and the idle after it.
  task automatic send_frame(input vec_t v);
    int bc;
    tx.P_DATA     = v.data;
    tx.PAR_EN     = v.pe;
    tx.PAR_TYP    = v.pt;
    tx.Data_Valid = 1'b1;
    @(negedge CLK);
    tx.Data_Valid = 1'b0;
    tx.P_DATA     = ~v.data;
    tx.PAR_EN     = ~v.pe;
    tx.PAR_TYP    = ~v.pt;
    check_frame(v.data, v.pe, v.exp_par, bc);
    chk("busy_len", bc[7:0], v.exp_busy[7:0]);
    @(negedge CLK);
    chk("idle_mux", {6'd0, tx.mux_sel}, 8'h01);
    chk("idle_busy", {7'd0, tx.busy}, 8'h00);
  endtask

  initial begin
    int bc;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1 + 8 + S};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1 + 8 + 1 + S};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1 + 8 + 1 + S};
    vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 1 + 8 + 1 + S};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0, 1 + 8 + 1 + S};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1 + 8 + 1 + S};

    RST           = 1'b1;
    tx.P_DATA     = 8'h00;
    tx.Data_Valid = 1'b0;
    tx.PAR_EN     = 1'b0;
    tx.PAR_TYP    = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_mux", {6'd0, tx.mux_sel}, 8'h01);
    chk("rst_busy", {7'd0, tx.busy}, 8'h00);
    chk("rst_ser", {7'd0, tx.ser_data}, 8'h00);
    chk("rst_par", {7'd0, tx.par_bit}, 8'h00);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) send_frame(vecs[i]);

    // Data_Valid held through a frame: 0x3C completes, one idle cycle, then 0xFF starts.
    tx.P_DATA     = 8'h3C;
    tx.PAR_EN     = 1'b0;
    tx.PAR_TYP    = 1'b0;
    tx.Data_Valid = 1'b1;
    @(negedge CLK);
    tx.P_DATA = 8'hFF;
    check_frame(8'h3C, 1'b0, 1'b0, bc);
    chk("hold_busy_len", bc[7:0], 8'(1 + 8 + S));
    @(negedge CLK);
    chk("hold_idle_busy", {7'd0, tx.busy}, 8'h00);
    chk("hold_idle_mux", {6'd0, tx.mux_sel}, 8'h01);
    @(negedge CLK);
    tx.Data_Valid = 1'b0;
    check_frame(8'hFF, 1'b0, 1'b0, bc);
    @(negedge CLK);
    chk("hold2_idle_busy", {7'd0, tx.busy}, 8'h00);

    // Reset in DATA bit 3 of a frame whose parity bit is 1.
    tx.P_DATA     = 8'h07;
    tx.PAR_EN     = 1'b1;
    tx.PAR_TYP    = 1'b0;
    tx.Data_Valid = 1'b1;
    @(negedge CLK);
    tx.Data_Valid = 1'b0;
    chk("mid_start_par", {7'd0, tx.par_bit}, 8'h01);
    repeat (4) @(negedge CLK);
    chk("mid_bit3_mux", {6'd0, tx.mux_sel}, 8'h02);
    chk("mid_bit3_ser", {7'd0, tx.ser_data}, 8'h00);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_mux", {6'd0, tx.mux_sel}, 8'h01);
    chk("mid_rst_busy", {7'd0, tx.busy}, 8'h00);
    chk("mid_rst_par", {7'd0, tx.par_bit}, 8'h00);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_busy", {7'd0, tx.busy}, 8'h00);
    send_frame(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
